song_player: RTL and testbench
==============================

// Module: song_player
// PURPOSE
//  Autoplay sequencer for the piano note path. Walks a song ROM of {note,duration} words and
//  drives the 5-bit note code (0 = silence, 1..21 = three octaves x 7 keys) into the buzzer.
//  Arbitrates the buzzer: the player owns it while a song runs, live keyboard note otherwise.
//  Sits between keyboard note decode / song ROM and the buzzer.
// PARAMETERS
//  TICK_CYCLES  12_500_000  clk cycles per duration unit (1/8 s at 100 MHz)
//  GAP_CYCLES   1_000_000   silent articulation gap after each ROM entry
//  ADDR_W       8           ROM address width; 4 songs of 2**(ADDR_W-2) words each
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       1-cycle pulse: begin song song_sel (ignored unless IDLE)
//  stop       in   1       abort playback (level or pulse); highest priority
//  pause      in   1       level: hold playback while high
//  song_sel   in   2       song index; base address = song_sel << (ADDR_W-2)
//  live_note  in   5       note code from keyboard decode (0..21)
//  rom_addr   out  ADDR_W  song ROM address (synchronous ROM, 1-cycle read latency)
//  rom_data   in   8       [7:3] note code, [2:0] duration-1 (1..8 units)
//  note_out   out  5       registered note code to buzzer
//  busy       out  1       high from start accept until return to IDLE
//  done       out  1       1-cycle pulse on normal song completion
// BEHAVIOUR
//  Reset: state IDLE, note_out=0, rom_addr=0, busy=0, done=0, all counters 0.
//  States: IDLE, FETCH, LOAD, PLAY, GAP, PAUSED, DONE. All outputs registered.
//  IDLE: note_out <= live_note each cycle (1-cycle latency). start -> rom_addr<=base, FETCH, busy<=1.
//  FETCH: ROM read in flight; -> LOAD next cycle; note_out=0.
//  LOAD: decode rom_data. note==31 (END) -> DONE. Else PLAY with
//        remaining = (dur+1)*TICK_CYCLES; note_out <= note if 1..21, else 0 (0 and 22..30 = rest).
//  Latency: start sampled at edge t -> rom_addr valid t+1 -> note_out valid t+3.
//  PLAY: hold note_out; count down; at 0 -> GAP, note_out<=0, gap count=GAP_CYCLES.
//  GAP: count down; at 0: if rom_addr is last word of song section -> DONE (no wrap);
//       else rom_addr<=rom_addr+1, FETCH.
//  PAUSED: entered from PLAY or GAP while pause=1; note_out=0; counters frozen; on pause=0
//       return to saved state, restoring note_out from latched note. pause has no effect in
//       IDLE/FETCH/LOAD/DONE (FETCH/LOAD complete, pause takes effect on the following cycle).
//  DONE: done=1 for one cycle, busy<=0, -> IDLE; note_out resumes live_note the next cycle.
//  stop in any non-IDLE state: -> IDLE next edge, note_out<=0 that cycle, busy<=0, no done.
//  start+stop same cycle in IDLE: stop wins, stays IDLE. start while busy: ignored.
//  Async rst mid-operation: immediate return to reset values, no done.
//  Counters: width ceil(log2(8*TICK_CYCLES+1)); no overflow possible.
// STRUCTURE
//  Shared defs (piano_defs): NOTE_REST=0, NOTE_MAX=21, NOTE_END=31, ROM word field
//  positions, state encoding.
//  One sub-module: beat_timer (loadable down-counter with enable/hold, zero flag), used for
//  both PLAY duration and GAP; FSM + arbitration mux stay in song_player.
// TESTING  (TICK_CYCLES=4, GAP_CYCLES=2)
//  1 Reset, IDLE, live_note=5 -> note_out=5 one cycle later; busy=0; rom_addr=0.
//  2 Song0 ROM {8,d=1},{10,d=0},{END}; start -> note_out=8 from t+3 for 8 cycles, 0 for 2,
//    10 for 4, 0 for 2, then FETCH/LOAD, done pulse once, busy low, note_out=live_note.
//  3 Same song, pause high 5 cycles mid first note -> note_out=0 during pause, note 8 totals
//    exactly 8 high cycles; sequence otherwise unchanged.
//  4 stop during PLAY of note 10 -> next cycle IDLE, busy=0, done never pulses; start+stop
//    together in IDLE -> stays IDLE.
//  5 song_sel=1, section 64..127 full of {25,d=0}, no END -> addr 64 first, note_out=0 for all
//    (invalid = rest), done after addr 127, rom_addr never reaches 128.
//  6 Async rst asserted mid-PLAY (off clock edge) -> note_out=0, busy=0 immediately;
//    start pulse while busy -> no restart, rom_addr unaffected.

Source files
------------

// File: rtl/song_player_pkg.sv
// Shared definitions for the piano autoplay path.
// Contents: note code constants, song ROM word field positions, sequencer
// state encoding and a helper that maps a ROM note field to a buzzer code.
package song_player_pkg;

  // Note codes: 0 is silence, 1..21 are playable keys, 31 marks end of song.
  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_MIN  = 5'd1;
  localparam logic [4:0] NOTE_MAX  = 5'd21;
  localparam logic [4:0] NOTE_END  = 5'd31;

  // Song ROM word layout: [7:3] note code, [2:0] duration minus one.
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 3;
  localparam int DUR_MSB  = 2;
  localparam int DUR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_GAP    = 3'd4,
    ST_PAUSED = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Codes outside 1..21 (0 and the unused 22..30) are played as a rest.
  function automatic logic [4:0] play_code(input logic [4:0] note);
    logic [4:0] code;
    if ((note >= NOTE_MIN) && (note <= NOTE_MAX)) begin
      code = note;
    end else begin
      code = NOTE_REST;
    end
    return code;
  endfunction

endpackage

// File: rtl/song_player_beat_timer.sv
// beat_timer: loadable down-counter shared by note duration and gap timing.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load load_val this cycle (takes priority over en)
//   en        - decrement by one while nonzero; count holds when low
//   load_val  - value to load
//   zero      - count currently equals zero
module beat_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load, decrement while enabled, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/song_player.sv
// song_player: autoplay sequencer and buzzer arbiter for the piano note path.
// Walks a song ROM of {note,duration} words and drives the 5-bit note code to
// the buzzer while a song runs; passes the live keyboard note through otherwise.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   start      - 1-cycle pulse, begin song song_sel (accepted only when idle)
//   stop       - abort playback, highest priority
//   pause      - level, hold playback (silent) while high
//   song_sel   - song index; section base = song_sel << (ADDR_W-2)
//   live_note  - keyboard note code
//   rom_addr   - synchronous song ROM address (1-cycle read latency)
//   rom_data   - ROM word: [7:3] note, [2:0] duration-1
//   note_out   - registered note code to the buzzer
//   busy       - high from start accept until return to idle
//   done       - 1-cycle pulse on normal song completion
module song_player
  import song_player_pkg::*;
#(
  parameter int TICK_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        song_sel,
  input  logic [4:0]        live_note,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [4:0]        note_out,
  output logic              busy,
  output logic              done
);

  localparam int SEC_W = ADDR_W - 2;
  localparam int CNT_W = $clog2(8 * TICK_CYCLES + 1);
  localparam logic [CNT_W-1:0] TICK_V   = CNT_W'(TICK_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [4:0]        note_lat_q, note_lat_d;
  logic [4:0]        note_out_q, note_out_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tmr_load;
  logic              tmr_en;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;

  logic [4:0]        rom_note;
  logic [2:0]        rom_dur;
  logic [CNT_W-1:0]  play_load;
  logic [ADDR_W-1:0] base_addr;
  logic              last_word;

  assign rom_note  = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
  // The timer counts down to zero inclusive, so load one less than the
  // number of cycles the note should sound.
  assign play_load = (({{(CNT_W-3){1'b0}}, rom_dur} + CNT_ONE) * TICK_V) - CNT_ONE;
  assign base_addr = {song_sel, {SEC_W{1'b0}}};
  assign last_word = &rom_addr_q[SEC_W-1:0];

  beat_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Sequencer next-state, buzzer arbitration and timer control.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    note_lat_d = note_lat_q;
    note_out_d = note_out_q;
    rom_addr_d = rom_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = {CNT_W{1'b0}};

    if (stop && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      note_out_d = NOTE_REST;
      busy_d     = 1'b0;
      tmr_load   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          note_out_d = live_note;
          if (start && !stop) begin
            rom_addr_d = base_addr;
            note_out_d = NOTE_REST;
            busy_d     = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          note_out_d = NOTE_REST;
          state_d    = ST_LOAD;
        end
        ST_LOAD: begin
          if (rom_note == NOTE_END) begin
            note_out_d = NOTE_REST;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else begin
            note_lat_d = play_code(rom_note);
            note_out_d = play_code(rom_note);
            tmr_load   = 1'b1;
            tmr_val    = play_load;
            state_d    = ST_PLAY;
          end
        end
        ST_PLAY: begin
          // Expiry beats pause; a cycle that enters pause still consumes
          // its count because the note was audible during it.
          if (tmr_zero) begin
            note_out_d = NOTE_REST;
            tmr_load   = 1'b1;
            tmr_val    = GAP_LOAD;
            state_d    = ST_GAP;
          end else if (pause) begin
            tmr_en     = 1'b1;
            note_out_d = NOTE_REST;
            ret_d      = ST_PLAY;
            state_d    = ST_PAUSED;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_GAP: begin
          note_out_d = NOTE_REST;
          if (tmr_zero) begin
            if (last_word) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              rom_addr_d = rom_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              state_d    = ST_FETCH;
            end
          end else if (pause) begin
            tmr_en  = 1'b1;
            ret_d   = ST_GAP;
            state_d = ST_PAUSED;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ret_q;
            if (ret_q == ST_PLAY) begin
              note_out_d = note_lat_q;
            end else begin
              note_out_d = NOTE_REST;
            end
          end else begin
            note_out_d = NOTE_REST;
          end
        end
        ST_DONE: begin
          busy_d     = 1'b0;
          note_out_d = live_note;
          state_d    = ST_IDLE;
        end
        default: begin
          busy_d     = 1'b0;
          note_out_d = NOTE_REST;
          state_d    = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_PLAY;
      note_lat_q <= NOTE_REST;
      note_out_q <= NOTE_REST;
      rom_addr_q <= {ADDR_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      note_lat_q <= note_lat_d;
      note_out_q <= note_out_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign note_out = note_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_song_player.sv
// Directed self-checking bench for song_player (TICK_CYCLES=4, GAP_CYCLES=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_song_player;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic [1:0] song_sel;
  logic [4:0] live_note;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [4:0] note_out;
  logic       busy;
  logic       done;

  logic [7:0] rom [0:255];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  song_player #(
    .TICK_CYCLES (4),
    .GAP_CYCLES  (2),
    .ADDR_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .song_sel  (song_sel),
    .live_note (live_note),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_out  (note_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM, one-cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected note_out for song 0, index i cycles after the start edge,
  // with an optional pause window of pl silent cycles beginning at ps.
  // Unpaused: FETCH,LOAD,8x note 8,GAP x2,FETCH,LOAD,4x note 10,GAP x2,FETCH,LOAD,DONE.
  function automatic logic [4:0] exp_song0(input int i, input int ps, input int pl);
    int j;
    j = i;
    if ((pl > 0) && (i >= ps) && (i < ps + pl)) return 5'd0;
    if ((pl > 0) && (i >= ps + pl)) j = i - pl;
    if ((j >= 2) && (j <= 9)) return 5'd8;
    if ((j >= 14) && (j <= 17)) return 5'd10;
    return 5'd0;
  endfunction

  initial begin
    int n8;
    int ndone;
    int nz;
    int outside;
    int didx;
    logic [7:0] daddr;

    for (int a = 0; a < 256; a++) rom[a] = 8'd0;
    rom[0] = {5'd8, 3'd1};
    rom[1] = {5'd10, 3'd0};
    rom[2] = {5'd31, 3'd0};
    for (int a = 64; a < 128; a++) rom[a] = {5'd25, 3'd0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    song_sel = 2'd0; live_note = 5'd5;

    // 1: reset values and live pass-through with one-cycle latency
    tick(); tick();
    chk("rst_note", note_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    rst = 1'b0;
    tick();
    chk("idle_live5", note_out, 5);
    chk("idle_busy", busy, 0);
    chk("idle_addr", rom_addr, 0);
    live_note = 5'd7;
    chk("idle_latency_hold", note_out, 5);
    tick();
    chk("idle_live7", note_out, 7);

    // 2: song 0 plays through
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i <= 22; i++) begin
      chk($sformatf("s0_note[%0d]", i), note_out, exp_song0(i, 0, 0));
      chk($sformatf("s0_done[%0d]", i), done, (i == 22) ? 1 : 0);
      chk($sformatf("s0_busy[%0d]", i), busy, 1);
      if (i == 0)  chk("s0_addr0", rom_addr, 0);
      if (i == 12) chk("s0_addr1", rom_addr, 1);
      if (i == 20) chk("s0_addr2", rom_addr, 2);
      tick();
    end
    chk("s0_end_note_live", note_out, 7);
    chk("s0_end_busy", busy, 0);
    chk("s0_end_done", done, 0);

    // 3: pause for five cycles during the first note
    n8 = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i <= 27; i++) begin
      chk($sformatf("p_note[%0d]", i), note_out, exp_song0(i, 5, 5));
      chk($sformatf("p_done[%0d]", i), done, (i == 27) ? 1 : 0);
      if (note_out === 5'd8) n8++;
      if (i == 4) pause = 1'b1;
      if (i == 9) pause = 1'b0;
      tick();
    end
    chk("p_note8_cycles", n8, 8);
    chk("p_end_busy", busy, 0);

    // 4: stop during note 10, then start+stop together while idle
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("stop_pre_note10", note_out, 10);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_note", note_out, 0);
    chk("stop_done", done, 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("stop_no_done", ndone, 0);
    chk("stop_idle_live", note_out, 7);
    song_sel = 2'd1;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_addr", rom_addr, 1);
    chk("ss_note_live", note_out, 7);
    tick();
    chk("ss_busy_later", busy, 0);

    // 5: song 1 is all invalid notes and has no END word
    live_note = 5'd9;
    start = 1'b1; tick(); start = 1'b0;
    chk("s1_first_addr", rom_addr, 64);
    chk("s1_busy", busy, 1);
    nz = 0; outside = 0; didx = -1; daddr = 8'd0;
    for (int i = 0; i < 600; i++) begin
      if (note_out !== 5'd0) nz++;
      if ((rom_addr < 8'd64) || (rom_addr > 8'd127)) outside++;
      if (done === 1'b1) begin
        didx  = i;
        daddr = rom_addr;
        break;
      end
      tick();
    end
    chk("s1_done_index", didx, 512);
    chk("s1_all_rest", nz, 0);
    chk("s1_addr_in_section", outside, 0);
    chk("s1_done_addr", daddr, 127);
    tick();
    chk("s1_end_live", note_out, 9);
    chk("s1_end_busy", busy, 0);

    // 6: asynchronous reset mid-play, then start while busy is ignored
    live_note = 5'd3; song_sel = 2'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("ar_pre_note", note_out, 8);
    #2 rst = 1'b1;
    #1;
    chk("ar_note", note_out, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", rom_addr, 0);
    chk("ar_done", done, 0);
    #1 rst = 1'b0;
    tick();
    chk("ar_after_live", note_out, 3);
    chk("ar_after_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    song_sel = 2'd1;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_start_addr", rom_addr, 0);
    chk("busy_start_busy", busy, 1);
    chk("busy_start_note", note_out, 8);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("final_stop_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
